// File: rtl/fpsu_cvt_sched.sv
// Round-robin scheduler sharing one fixed-latency convert unit among FP lanes.
// Issue register, lane tag pipeline and registered result return.
module fpsu_cvt_sched #(
    parameter int LANES = 3,
    parameter int LAT   = 2,
    parameter int DW    = 68
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LANES-1:0]   req_vld,
    input  logic [LANES-1:0]   req_dbl,
    input  logic [LANES*DW-1:0] req_data,
    output logic [LANES-1:0]   req_rdy,
    input  logic               wb_busy,
    input  logic               flush,
    output logic               cvt_en,
    output logic               cvt_dbl,
    output logic [DW-1:0]      cvt_A,
    input  logic [DW-1:0]      cvt_res,
    input  logic               cvt_alt,
    output logic [LANES-1:0]   res_vld,
    output logic [DW-1:0]      res_data,
    output logic               res_alt,
    output logic [2:0]         inflight
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LW-1:0] ptr;
    logic [LW-1:0] gnt_lane;
    logic [LW-1:0] iss_lane;
    logic          gnt;
    logic [DW-1:0] gnt_data;
    logic [LAT-1:0] tag_v;
    logic [LW-1:0] tag_l [LAT];
    logic          done;

    // ptr holds the highest-priority lane for the next grant
    always_comb begin
        int idx;
        idx = 0;
        gnt = 1'b0;
        gnt_lane = '0;
        for (int k = 0; k < LANES; k++) begin
            idx = int'(ptr) + k;
            if (idx >= LANES) idx = idx - LANES;
            if (!gnt && req_vld[idx]) begin
                gnt = 1'b1;
                gnt_lane = LW'(idx);
            end
        end
        if (rst || wb_busy || flush) gnt = 1'b0;
    end

    assign req_rdy  = LANES'(gnt) << gnt_lane;
    assign gnt_data = req_data[int'(gnt_lane)*DW +: DW];
    assign done     = tag_v[LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            cvt_en   <= 1'b0;
            cvt_dbl  <= 1'b0;
            cvt_A    <= '0;
            iss_lane <= '0;
        end else begin
            cvt_en <= gnt;
            if (gnt) begin
                cvt_dbl  <= req_dbl[gnt_lane];
                cvt_A    <= gnt_data;
                iss_lane <= gnt_lane;
                ptr      <= (gnt_lane == LW'(LANES-1)) ? '0 : gnt_lane + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            tag_v <= '0;
        end else begin
            tag_v[0] <= cvt_en;
            for (int i = 1; i < LAT; i++) tag_v[i] <= tag_v[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) tag_l[i] <= '0;
        end else begin
            tag_l[0] <= iss_lane;
            for (int i = 1; i < LAT; i++) tag_l[i] <= tag_l[i-1];
        end
    end

    // a result already at the tag tail survives a same-cycle flush
    always_ff @(posedge clk) begin
        if (rst) begin
            res_vld  <= '0;
            res_data <= '0;
            res_alt  <= 1'b0;
        end else begin
            res_vld <= '0;
            if (done) begin
                res_vld  <= LANES'(1) << tag_l[LAT-1];
                res_data <= cvt_res;
                res_alt  <= cvt_alt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            inflight <= '0;
        end else if (gnt && !done) begin
            inflight <= inflight + 3'd1;
        end else if (!gnt && done) begin
            inflight <= inflight - 3'd1;
        end
    end

endmodule

// File: tb/tb_fpsu_cvt_sched.sv
// Bench for fpsu_cvt_sched: directed scenarios plus random traffic
// checked against a queue-based model of accepted conversions.
module tb_fpsu_cvt_sched;

    localparam int LANES = 3;
    localparam int LAT   = 2;
    localparam int DW    = 68;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [LANES-1:0]   req_vld;
    logic [LANES-1:0]   req_dbl;
    logic [LANES*DW-1:0] req_data;
    logic [LANES-1:0]   req_rdy;
    logic               wb_busy;
    logic               flush;
    logic               cvt_en;
    logic               cvt_dbl;
    logic [DW-1:0]      cvt_A;
    logic [DW-1:0]      cvt_res;
    logic               cvt_alt;
    logic [LANES-1:0]   res_vld;
    logic [DW-1:0]      res_data;
    logic               res_alt;
    logic [2:0]         inflight;

    fpsu_cvt_sched #(.LANES(LANES), .LAT(LAT), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_dbl(req_dbl), .req_data(req_data),
        .req_rdy(req_rdy), .wb_busy(wb_busy), .flush(flush),
        .cvt_en(cvt_en), .cvt_dbl(cvt_dbl), .cvt_A(cvt_A),
        .cvt_res(cvt_res), .cvt_alt(cvt_alt),
        .res_vld(res_vld), .res_data(res_data), .res_alt(res_alt),
        .inflight(inflight)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct { int t; int lane; } item_t;
    item_t q[$];
    int ptr_m = 0;
    int e_g;
    logic [2:0] e_rdy, e_vld, e_infl;
    logic e_en, e_dbl, e_alt;
    logic [DW-1:0] e_A, e_data;

    function automatic logic [DW-1:0] rnd();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // drives one cycle of inputs and predicts the grant
    task automatic drive(input logic [2:0] v, input logic [2:0] d,
                         input logic b, input logic f, input logic r);
        req_vld = v; req_dbl = d; wb_busy = b; flush = f; rst = r;
        req_data = {rnd(), rnd(), rnd()};
        cvt_res = rnd();
        cvt_alt = 1'($urandom_range(0, 1));
        e_g = -1;
        if (!(r || b || f)) begin
            for (int k = 0; k < 3; k++) begin
                int idx;
                idx = (ptr_m + k) % 3;
                if (e_g < 0 && v[idx]) e_g = idx;
            end
        end
        e_rdy = (e_g < 0) ? 3'b000 : 3'(1 << e_g);
    endtask

    // advances the model across the clock edge, then waits for mid-cycle
    task automatic tick();
        if (rst) begin
            q.delete();
            ptr_m = 0;
            e_en = 0; e_dbl = 0; e_A = '0;
            e_vld = 0; e_data = '0; e_alt = 0;
        end else begin
            e_vld = 3'b000;
            if (q.size() > 0 && q[0].t + 1 + LAT == cyc) begin
                e_vld = 3'(1 << q[0].lane);
                e_data = cvt_res;
                e_alt = cvt_alt;
                void'(q.pop_front());
            end
            if (flush) q.delete();
            if (e_g >= 0) begin
                q.push_back('{cyc, e_g});
                ptr_m = (e_g + 1) % 3;
                e_en = 1;
                e_dbl = req_dbl[e_g];
                e_A = req_data[e_g*DW +: DW];
            end else begin
                e_en = 0;
            end
        end
        e_infl = 3'(q.size());
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(3'b000, 3'b000, 0, 0, 1); #1; tick();
        drive(3'b111, 3'b000, 0, 0, 1); #1;
        total++;
        if (req_rdy !== 3'b000) begin
            bad++; $display("FAIL reset_rdy got=%b exp=000", req_rdy);
        end
        tick();
        drive(3'b000, 3'b000, 0, 0, 0); #1;
        total++;
        if ({req_rdy, cvt_en, cvt_dbl, res_vld, res_alt, inflight} !== 12'd0) begin
            bad++;
            $display("FAIL reset_ctl got=%h exp=0",
                     {req_rdy, cvt_en, cvt_dbl, res_vld, res_alt, inflight});
        end
        total++;
        if (cvt_A !== '0 || res_data !== '0) begin
            bad++; $display("FAIL reset_data got=%h/%h exp=0/0", cvt_A, res_data);
        end
        tick();
    endtask

    task automatic test_single();
        logic [DW-1:0] r3;
        r3 = '0;
        for (int c = 0; c < 7; c++) begin
            drive((c == 0) ? 3'b010 : 3'b000, 3'b010, 0, 0, 0);
            if (c == 0) begin
                req_data[DW +: DW] = 68'h3FF0000000000000;
                e_rdy = 3'b010;
            end
            if (c == 3) r3 = cvt_res;
            #1;
            total++;
            if ({req_rdy, cvt_en, res_vld, inflight} !== {e_rdy, e_en, e_vld, e_infl}) begin
                bad++;
                $display("FAIL single_ctl c=%0d got=%h exp=%h", c,
                         {req_rdy, cvt_en, res_vld, inflight}, {e_rdy, e_en, e_vld, e_infl});
            end
            if (c == 0) begin
                total++;
                if (req_rdy !== 3'b010) begin
                    bad++; $display("FAIL single_rdy got=%b exp=010", req_rdy);
                end
            end
            if (c == 1) begin
                total++;
                if ({cvt_en, cvt_dbl, cvt_A} !== {2'b11, 68'h3FF0000000000000}) begin
                    bad++;
                    $display("FAIL single_issue got=%b%b %h exp=11 3ff0000000000000",
                             cvt_en, cvt_dbl, cvt_A);
                end
            end
            if (c == 4) begin
                total++;
                if (res_vld !== 3'b010 || res_data !== r3) begin
                    bad++;
                    $display("FAIL single_res got=%b %h exp=010 %h", res_vld, res_data, r3);
                end
            end
            tick();
        end
    endtask

    task automatic test_contention();
        int g_tab [6] = '{0, 1, 2, 0, 1, 2};
        int pk;
        pk = 0;
        drive(3'b000, 3'b000, 0, 0, 1); #1; tick();
        for (int c = 0; c < 10; c++) begin
            drive((c < 6) ? 3'b111 : 3'b000, 3'($urandom), 0, 0, 0); #1;
            if (int'(inflight) > pk) pk = int'(inflight);
            total++;
            if ({req_rdy, cvt_en, res_vld, inflight} !== {e_rdy, e_en, e_vld, e_infl}) begin
                bad++;
                $display("FAIL cont_ctl c=%0d got=%h exp=%h", c,
                         {req_rdy, cvt_en, res_vld, inflight}, {e_rdy, e_en, e_vld, e_infl});
            end
            if (c < 6) begin
                total++;
                if (req_rdy !== 3'(1 << g_tab[c])) begin
                    bad++; $display("FAIL cont_gnt c=%0d got=%b exp=%b", c, req_rdy,
                                    3'(1 << g_tab[c]));
                end
            end
            if (c >= 4) begin
                total++;
                if (res_vld !== 3'(1 << g_tab[c-4]) || res_data !== e_data) begin
                    bad++; $display("FAIL cont_res c=%0d got=%b %h exp=%b %h", c, res_vld,
                                    res_data, 3'(1 << g_tab[c-4]), e_data);
                end
            end
            tick();
        end
        total++;
        if (pk != 3) begin
            bad++; $display("FAIL cont_peak got=%0d exp=3", pk);
        end
    endtask

    task automatic test_busy();
        logic [2:0] rdy_tab [4] = '{3'b100, 3'b000, 3'b000, 3'b100};
        for (int c = 0; c < 9; c++) begin
            drive((c <= 3) ? 3'b100 : 3'b000, 3'b000, (c == 1 || c == 2), 0, 0); #1;
            total++;
            if ({req_rdy, cvt_en, res_vld, inflight} !== {e_rdy, e_en, e_vld, e_infl}) begin
                bad++;
                $display("FAIL busy_ctl c=%0d got=%h exp=%h", c,
                         {req_rdy, cvt_en, res_vld, inflight}, {e_rdy, e_en, e_vld, e_infl});
            end
            if (c <= 3) begin
                total++;
                if (req_rdy !== rdy_tab[c]) begin
                    bad++; $display("FAIL busy_rdy c=%0d got=%b exp=%b", c, req_rdy, rdy_tab[c]);
                end
            end
            if (c == 4 || c == 7) begin
                total++;
                if (res_vld !== 3'b100 || res_data !== e_data) begin
                    bad++; $display("FAIL busy_res c=%0d got=%b %h exp=100 %h", c, res_vld,
                                    res_data, e_data);
                end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        drive(3'b000, 3'b000, 0, 0, 1); #1; tick();
        for (int c = 0; c < 9; c++) begin
            drive((c <= 3) ? 3'b111 : 3'b000, 3'($urandom), 0, (c == 3), 0); #1;
            total++;
            if ({req_rdy, cvt_en, res_vld, inflight} !== {e_rdy, e_en, e_vld, e_infl}) begin
                bad++;
                $display("FAIL flush_ctl c=%0d got=%h exp=%h", c,
                         {req_rdy, cvt_en, res_vld, inflight}, {e_rdy, e_en, e_vld, e_infl});
            end
            if (c == 3) begin
                total++;
                if (req_rdy !== 3'b000) begin
                    bad++; $display("FAIL flush_rdy got=%b exp=000", req_rdy);
                end
            end
            if (c == 4) begin
                total++;
                if ({res_vld, inflight, cvt_en} !== {3'b001, 3'd0, 1'b0}) begin
                    bad++; $display("FAIL flush_c4 got=%b %0d %b exp=001 0 0",
                                    res_vld, inflight, cvt_en);
                end
            end
            if (c >= 5) begin
                total++;
                if (res_vld !== 3'b000) begin
                    bad++; $display("FAIL flush_kill c=%0d got=%b exp=000", c, res_vld);
                end
            end
            tick();
        end
    endtask

    task automatic test_rst_mid();
        for (int c = 0; c < 8; c++) begin
            drive((c <= 3) ? 3'b111 : 3'b000, 3'($urandom), 0, 0, (c == 2)); #1;
            total++;
            if ({req_rdy, cvt_en, res_vld, inflight} !== {e_rdy, e_en, e_vld, e_infl}) begin
                bad++;
                $display("FAIL rstm_ctl c=%0d got=%h exp=%h", c,
                         {req_rdy, cvt_en, res_vld, inflight}, {e_rdy, e_en, e_vld, e_infl});
            end
            if (c == 3) begin
                total++;
                if ({cvt_en, cvt_dbl, res_vld, res_alt, inflight} !== 9'd0 ||
                    cvt_A !== '0 || res_data !== '0) begin
                    bad++; $display("FAIL rstm_zero got=%b%b %b %b %0d %h %h exp=zero",
                                    cvt_en, cvt_dbl, res_vld, res_alt, inflight, cvt_A, res_data);
                end
                total++;
                if (req_rdy !== 3'b001) begin
                    bad++; $display("FAIL rstm_gnt got=%b exp=001", req_rdy);
                end
            end
            if (c >= 4 && c <= 6) begin
                total++;
                if (res_vld !== 3'b000) begin
                    bad++; $display("FAIL rstm_kill c=%0d got=%b exp=000", c, res_vld);
                end
            end
            if (c == 7) begin
                total++;
                if (res_vld !== 3'b001) begin
                    bad++; $display("FAIL rstm_new got=%b exp=001", res_vld);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        drive(3'b000, 3'b000, 0, 0, 1); #1; tick();
        for (int c = 0; c < 400; c++) begin
            drive(3'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0)); #1;
            total++;
            if ({req_rdy, cvt_en, res_vld, inflight} !== {e_rdy, e_en, e_vld, e_infl}) begin
                bad++;
                $display("FAIL rand_ctl c=%0d got=%h exp=%h", c,
                         {req_rdy, cvt_en, res_vld, inflight}, {e_rdy, e_en, e_vld, e_infl});
            end
            total++;
            if ({cvt_dbl, cvt_A} !== {e_dbl, e_A}) begin
                bad++; $display("FAIL rand_issue c=%0d got=%b %h exp=%b %h", c,
                                cvt_dbl, cvt_A, e_dbl, e_A);
            end
            total++;
            if ({res_alt, res_data} !== {e_alt, e_data}) begin
                bad++; $display("FAIL rand_res c=%0d got=%b %h exp=%b %h", c,
                                res_alt, res_data, e_alt, e_data);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1; req_vld = 0; req_dbl = 0; req_data = '0;
        wb_busy = 0; flush = 0; cvt_res = '0; cvt_alt = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_busy();
        test_flush();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpsu_cvt_sched.md
FPSU_CVT_SCHED -- requirements
Module: fpsu_cvt_sched

Interface
REQ-001 SHALL have parameter LANES, default 3: number of FP lanes sharing the convert unit (u1, u3, u5 mapped to lanes 0, 1, 2).
REQ-002 SHALL have parameter LAT, default 2: fixed convert-unit latency in cycles, from cvt_en to cvt_res valid.
REQ-003 SHALL have parameter DW, default 68: operand and result width.
REQ-004 SHALL have clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have req_vld, input, LANES: per-lane convert request valid.
REQ-007 SHALL have req_dbl, input, LANES: per-lane op select; 1 = pcvtD, 0 = pcvtS.
REQ-008 SHALL have req_data, input, LANES*DW: per-lane operand; lane i occupies [DW*i+DW-1 : DW*i].
REQ-009 SHALL have req_rdy, output, LANES: one-hot grant; the request is accepted in any cycle where req_vld[i] and req_rdy[i] are both high.
REQ-010 SHALL have wb_busy, input, 1: writeback port unavailable; while high, no grant is issued.
REQ-011 SHALL have flush, input, 1: kills the pending issue and all in-flight conversions.
REQ-012 SHALL have cvt_en, output, 1: issue strobe to the convert unit.
REQ-013 SHALL have cvt_dbl, output, 1: isDBL to the convert unit; its complement drives isSNG/is32b.
REQ-014 SHALL have cvt_A, output, DW: operand to the convert unit.
REQ-015 SHALL have cvt_res, input, DW, and cvt_alt, input, 1: convert-unit result and alt flag.
REQ-016 SHALL have res_vld, output, LANES: one-hot result-valid, indicating the owning lane.
REQ-017 SHALL have res_data, output, DW, and res_alt, output, 1: registered result and alt flag.
REQ-018 SHALL have inflight, output, 3: count of accepted, not yet returned conversions.

Function
REQ-019 SHALL grant at most one lane per cycle, using round-robin priority that starts at the lane after the last granted lane.
REQ-020 SHALL drive req_rdy combinationally from req_vld, the RR pointer, wb_busy and flush, and SHALL drive it all-zero when wb_busy or flush is high.
REQ-021 SHALL advance the RR pointer only on an accepted grant; with no grant the pointer holds.
REQ-022 SHALL, for a request accepted in cycle T, register cvt_en=1, cvt_dbl and cvt_A so they are valid in cycle T+1; otherwise cvt_en SHALL be 0 and cvt_A/cvt_dbl SHALL hold.
REQ-023 SHALL track ownership in a LAT-deep tag shift register of {valid, lane} that advances every cycle.
REQ-024 SHALL, when the tag valid emerges in cycle T+1+LAT, capture cvt_res and cvt_alt so that res_vld[lane]=1, res_data and res_alt are valid in cycle T+2+LAT (T+4 with the default LAT).
REQ-025 SHALL hold res_vld high for exactly one cycle per result; res_data SHALL hold its value when res_vld is 0.
REQ-026 SHALL sustain back-to-back accepts: one per cycle, results returned in grant order, one per cycle.
REQ-027 SHALL update inflight as +1 on accept and -1 on result; with both in the same cycle it SHALL be unchanged; the maximum is LAT+1.
REQ-028 SHALL, on flush, clear the issue register and all tag valids on the next edge: cvt_en=0 next cycle, no res_vld for killed work, inflight=0; the RR pointer is unchanged.
REQ-029 SHALL still emit a result whose res_vld register is being loaded in the flush cycle; flush kills only work not yet at the output register.
REQ-030 SHALL NOT let wb_busy affect conversions already in flight.
REQ-031 SHALL drop a req_vld that deasserts without a grant, with no state change.

Reset
REQ-032 SHALL, on rst high at a clock edge, set req_rdy-related state, cvt_en, cvt_dbl, cvt_A, res_vld, res_data, res_alt, inflight, all tag valids and the RR pointer to 0 (lane 0 highest priority).
REQ-033 SHALL, when rst is asserted mid-operation, discard all in-flight conversions; no res_vld SHALL appear after the reset edge until new requests are accepted.
REQ-034 SHALL give rst priority over flush and over any request.

Verification
REQ-035 Single request: lane 1, pcvtD, data=0x3FF0000000000000, cycle 0 -> req_rdy=3'b010 in cycle 0; cvt_en=1, cvt_dbl=1 in cycle 1; res_vld=3'b010 in cycle 4, carrying cvt_res.
REQ-036 Contention: req_vld=3'b111 held for 6 cycles after reset -> grant order lane 0,1,2,0,1,2; res_vld follows the same order in cycles 4..9; inflight peaks at 3.
REQ-037 wb_busy high in cycles 1-2 with lane 2 requesting -> req_rdy=0 in cycles 1-2; grant in cycle 3; in-flight results still delivered.
REQ-038 Flush: three accepts in cycles 0-2, flush in cycle 3 -> result for cycle 0 returned in cycle 4; no res_vld for cycles 1-2; inflight=0 in cycle 4.
REQ-039 Reset mid-stream: rst in cycle 2 after accepts in cycles 0-1 -> all outputs 0 from cycle 3; no res_vld; next grant goes to lane 0.
